// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution block scheduler: state encoding,
// default bank count, a constant-foldable clog2 and the lane-mask generator.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_RUN    = 3'd2,
    S_ROTATE = 3'd3,
    S_LOAD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int N_LANES = 2;
  localparam int BANKS   = N_LANES + 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // LSB-first mask of min(lanes, remaining) active lanes.
  function automatic logic [31:0] lane_mask(input int lanes, input int remaining);
    int count;
    count = (remaining < lanes) ? remaining : lanes;
    if (count < 0) count = 0;
    return (count >= 32) ? '1 : ((32'd1 << count) - 32'd1);
  endfunction

endpackage

// File: rtl/conv_block_scheduler_bank_rotator.sv
// Holds the physical bank of logical column 0 (base), rotates it by N modulo
// N+2 between blocks, and decodes a logical column into a one-hot write enable.
module bank_rotator
  import conv_sched_pkg::*;
#(
  parameter int N      = N_LANES,
  parameter int BANK_W = clog2(N_LANES + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic              write,
  input  logic [BANK_W-1:0] col,
  output logic [BANK_W-1:0] base,
  output logic [N+1:0]      we
);

  localparam int NBANK = N + 2;

  logic [BANK_W:0]   adv_sum;
  logic [BANK_W:0]   phys_sum;
  logic [BANK_W-1:0] phys;

  assign adv_sum  = {1'b0, base} + (BANK_W+1)'(N);
  assign phys_sum = {1'b0, base} + {1'b0, col};

  // Both operands are below N+2, so one conditional subtract is a full modulo.
  always_comb begin
    phys = phys_sum[BANK_W-1:0];
    if (phys_sum >= (BANK_W+1)'(NBANK)) phys = BANK_W'(phys_sum - (BANK_W+1)'(NBANK));
  end

  assign we = write ? ({{(N+1){1'b0}}, 1'b1} << phys) : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
    end else if (clear) begin
      base <= '0;
    end else if (advance) begin
      base <= (adv_sum >= (BANK_W+1)'(NBANK)) ? base - BANK_W'(2) : base + BANK_W'(N);
    end
  end

endmodule

// File: rtl/conv_block_scheduler.sv
// Frame sequencer for N Conv lanes over N+2 rotating column banks.
// Optional macro BLKSCHED_STALL_EN adds i_out_ready back-pressure on the read sweep.
module conv_block_scheduler
  import conv_sched_pkg::*;
#(
  parameter int N          = N_LANES,
  parameter int NB_ADDRESS = 10,
  parameter int BANK_W     = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_ADDRESS-1:0] i_img_len,
  input  logic                  i_pix_valid,
`ifdef BLKSCHED_STALL_EN
  input  logic                  i_out_ready,
`endif
  output logic                  o_pix_ready,
  output logic [N+1:0]          o_we,
  output logic [NB_ADDRESS-1:0] o_waddr,
  output logic [NB_ADDRESS-1:0] o_raddr,
  output logic [BANK_W-1:0]     o_base,
  output logic                  o_conv_valid,
  output logic [N-1:0]          o_lane_mask,
  output logic                  o_chblk,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic                  o_busy,
  output logic                  o_err
);

  state_t state, state_next;

  logic [NB_ADDRESS-1:0] len;
  logic [NB_ADDRESS-1:0] row;
  logic [BANK_W-1:0]     col;
  logic [NB_ADDRESS-1:0] cols_loaded;
  logic [NB_ADDRESS-1:0] outcols;
  logic [NB_ADDRESS-1:0] raddr;
  logic [N-1:0]          block_mask;
  logic                  conv_valid;
  logic                  sop_pend;
  logic                  err;

  logic                  start_ok;
  logic                  pix_acc;
  logic                  row_last;
  logic                  col_last;
  logic                  load_end;
  logic                  run_adv;
  logic                  run_last;
  logic [NB_ADDRESS-1:0] remaining;
  logic [NB_ADDRESS-1:0] blk_cols;

  assign start_ok    = (state == S_IDLE) && i_start && (i_img_len >= NB_ADDRESS'(3));
  assign o_pix_ready = (state == S_FILL) || (state == S_LOAD);
  assign pix_acc     = o_pix_ready && i_pix_valid;
  assign row_last    = (row == len - NB_ADDRESS'(1));
  // A load ends at the top logical column or when the image runs out of columns.
  assign col_last    = (col == BANK_W'(N + 1)) || (cols_loaded + NB_ADDRESS'(1) == len);
  assign load_end    = pix_acc && row_last && col_last;

`ifdef BLKSCHED_STALL_EN
  assign run_adv = (state == S_RUN) && i_out_ready;
`else
  assign run_adv = (state == S_RUN);
`endif
  assign run_last = run_adv && (raddr == len - NB_ADDRESS'(1));

  assign remaining = len - NB_ADDRESS'(2) - outcols;
  assign blk_cols  = (remaining > NB_ADDRESS'(N)) ? NB_ADDRESS'(N) : remaining;

  bank_rotator #(
    .N      (N),
    .BANK_W (BANK_W)
  ) u_rotator (
    .clk     (i_CLK),
    .rst_n   (i_rst),
    .clear   (start_ok),
    .advance (state == S_ROTATE),
    .write   (pix_acc),
    .col     (col),
    .base    (o_base),
    .we      (o_we)
  );

  // NOTE: the default is assigned before the case so no path leaves
  // state_next unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:         if (start_ok) state_next = S_FILL;
      S_FILL, S_LOAD: if (load_end) state_next = S_RUN;
      S_RUN:          if (run_last) state_next = (cols_loaded == len) ? S_DONE : S_ROTATE;
      S_ROTATE:       state_next = S_LOAD;
      S_DONE:         state_next = S_IDLE;
      default:        state_next = S_IDLE;
    endcase
  end

  // NOTE: every register, including counters and the mask, is cleared by the
  // asynchronous reset so an aborted frame leaves no residue.
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      len         <= '0;
      row         <= '0;
      col         <= '0;
      cols_loaded <= '0;
      outcols     <= '0;
      raddr       <= '0;
      block_mask  <= '0;
      conv_valid  <= 1'b0;
      sop_pend    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state      <= state_next;
      conv_valid <= run_adv;
      err        <= (state == S_IDLE) && i_start && (i_img_len < NB_ADDRESS'(3));

      if (start_ok) begin
        len         <= i_img_len;
        row         <= '0;
        col         <= '0;
        cols_loaded <= '0;
        outcols     <= '0;
        raddr       <= '0;
        sop_pend    <= 1'b1;
      end

      if (pix_acc) begin
        if (row_last) begin
          row         <= '0;
          col         <= col + BANK_W'(1);
          cols_loaded <= cols_loaded + NB_ADDRESS'(1);
        end else begin
          row <= row + NB_ADDRESS'(1);
        end
      end

      // Output columns of the upcoming block are fixed when its data is loaded.
      if (load_end) begin
        block_mask <= N'(lane_mask(N, int'(remaining)));
        outcols    <= outcols + blk_cols;
      end

      if (state == S_ROTATE) col <= BANK_W'(2);

      if (run_adv) raddr <= run_last ? '0 : raddr + NB_ADDRESS'(1);

      if (state == S_RUN) sop_pend <= 1'b0;
    end
  end

  assign o_waddr      = row;
  assign o_raddr      = raddr;
  assign o_conv_valid = conv_valid;
  assign o_lane_mask  = ((state == S_RUN) || conv_valid) ? block_mask : '0;
  assign o_chblk      = (state == S_ROTATE);
  assign o_sop        = (state == S_RUN) && sop_pend;
  assign o_eop        = (state == S_DONE);
  assign o_busy       = (state != S_IDLE);
  assign o_err        = err;

endmodule
